fetch_prefetch_queue: RTL

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue_pkg.sv | 22 ++
 rtl/fetch_prefetch_queue_sync_fifo.sv | 71 +++++++
 rtl/fetch_prefetch_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch types: FSM states, instruction width, reset PC.
// Imported by the fetch queue, decoder and datapath.
package fetch_prefetch_queue_pkg;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] PKG_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WAIT_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with registered head, flush and count.
// Ports: push/din, pop, flush, dout/valid head, count occupancy.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0) && !flush;
    push_ok = push && !flush &&
              ((count_q != CW'(DEPTH)) || pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    dout_d   = dout_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      // queue drained by this pop: new head is the entry being pushed
      dout_d = (count_q == CW'(pop_ok)) ? din
                                         : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = dout_q;
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: one outstanding fetch, queue to decoder.
// Ports: imem_* request/response, instr_* head, branch_* redirect.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [ILEN-1:0] RESET_PC = PKG_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [ILEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [ILEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            branch_en,
  input  logic [ILEN-1:0] branch_addr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [ILEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count;
  logic            can_req;
  logic            push;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  always_comb begin
    can_req  = (state_q == ST_IDLE) &&
               (count < CW'(DEPTH)) && !branch_en;
    imem_req = can_req && !rst;
    push     = 1'b0;
    state_d  = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (can_req) begin
          state_d    = ST_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_IDLE;
          push    = !branch_en && !rst;
        end else if (branch_en) begin
          state_d = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (branch_en) begin
      fetch_pc_d = branch_addr & ~32'h3;
    end
    // fetch_pc is untouched while in WAIT, so the request PC is one word back
    push_entry.pc   = fetch_pc_q - 32'd4;
    push_entry.insn = imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (instr_ready),
    .flush (branch_en),
    .dout  (head),
    .valid (instr_valid),
    .count (count)
  );

  assign imem_addr = fetch_pc_q;
  assign instr     = head.insn;
  assign instr_pc  = head.pc;

endmodule
